// File: rtl/part_2_trgt_apply.sv
// Target-side vector applier: per-slot FIFOs feed the DUT one vector per mission-clock edge,
// freezing a slot's clock when its FIFO runs dry and flagging a stalled link via a watchdog.
module part_2_trgt_apply #(
    parameter int N_SLOT   = 3,
    parameter int DW       = 9,
    parameter int DEPTH    = 4,
    parameter int WD_LIMIT = 10000,
    parameter int WD_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_SLOT-1:0]    mclk_h,
    input  logic [N_SLOT-1:0]    rcv_valid,
    input  logic [N_SLOT*DW-1:0] rcv_data,
    output logic [N_SLOT-1:0]    rcv_ready,
    output logic [N_SLOT*DW-1:0] dut_vec,
    output logic [N_SLOT-1:0]    dut_vec_upd,
    output logic [N_SLOT-1:0]    freeze_clk,
    output logic [N_SLOT-1:0]    wd_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    genvar k;
    for (k = 0; k < N_SLOT; k++) begin : g_slot
        logic [DW-1:0]   r_mem [DEPTH];
        logic [AW:0]     r_wptr;
        logic [AW:0]     r_rptr;
        logic            r_mclk_d;
        logic [WD_W-1:0] r_wd;
        logic [DW-1:0]   r_vec;
        logic            r_upd;
        logic            r_freeze;
        logic            r_err;
        state_t          r_state;
        state_t          w_next;
        logic            w_full;
        logic            w_empty;
        logic            w_push;
        logic            w_pop;
        logic            w_edge;
        logic            w_wd_clr;
        logic            w_wd_inc;

        // Extra pointer bit distinguishes full from empty when the low bits match.
        assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_empty = (r_wptr == r_rptr);
        assign w_push  = rcv_valid[k] & ~w_full;
        assign w_edge  = mclk_h[k] & ~r_mclk_d;

        // Slot FSM next-state, pop and watchdog control.
        always_comb begin
            w_next   = r_state;
            w_pop    = 1'b0;
            w_wd_clr = 1'b0;
            w_wd_inc = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_RUN;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_edge) begin
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            w_next = ST_RUN;
                        end else begin
                            w_wd_clr = 1'b1;
                            w_next   = ST_STARVED;
                        end
                    end else begin
                        w_next = ST_RUN;
                    end
                end
                ST_STARVED: begin
                    w_wd_inc = 1'b1;
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_RUN;
                    end else if (r_wd == WD_W'(WD_LIMIT - 1)) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next = ST_STARVED;
                    end
                end
                ST_ERROR: begin
                    w_next = ST_ERROR;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end

        // FIFO storage; contents are don't-care while the pointers say empty.
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= rcv_data[k*DW +: DW];
            end
        end

        // Slot state, pointers, watchdog and registered outputs.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state  <= ST_IDLE;
                r_wptr   <= {(AW+1){1'b0}};
                r_rptr   <= {(AW+1){1'b0}};
                r_mclk_d <= 1'b0;
                r_wd     <= {WD_W{1'b0}};
                r_vec    <= {DW{1'b0}};
                r_upd    <= 1'b0;
                r_freeze <= 1'b1;
                r_err    <= 1'b0;
            end else begin
                r_state  <= w_next;
                r_mclk_d <= mclk_h[k];
                if (w_push) begin
                    r_wptr <= r_wptr + (AW+1)'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + (AW+1)'(1);
                    r_vec  <= r_mem[r_rptr[AW-1:0]];
                end
                if (w_wd_clr) begin
                    r_wd <= {WD_W{1'b0}};
                end else if (w_wd_inc) begin
                    r_wd <= r_wd + WD_W'(1);
                end
                r_upd    <= w_pop;
                r_freeze <= (w_next != ST_RUN);
                // Error flag trails the ERROR state by one cycle.
                r_err    <= (r_state == ST_ERROR);
            end
        end

        assign rcv_ready[k]          = ~w_full;
        assign dut_vec[k*DW +: DW]   = r_vec;
        assign dut_vec_upd[k]        = r_upd;
        assign freeze_clk[k]         = r_freeze;
        assign wd_err[k]             = r_err;
    end

endmodule

// File: tb/tb_part_2_trgt_apply.sv
// Directed bench for part_2_trgt_apply: a per-cycle vector table plus hand-written
// sequences for FIFO fill, watchdog expiry, starvation release and mid-run reset.
module tb_part_2_trgt_apply;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  mclk_h = 3'b000;
    logic [2:0]  rcv_valid = 3'b000;
    logic [26:0] rcv_data = 27'd0;
    logic [2:0]  rcv_ready;
    logic [26:0] dut_vec;
    logic [2:0]  dut_vec_upd;
    logic [2:0]  freeze_clk;
    logic [2:0]  wd_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    part_2_trgt_apply #(
        .N_SLOT(3), .DW(9), .DEPTH(4), .WD_LIMIT(20), .WD_W(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mclk_h(mclk_h), .rcv_valid(rcv_valid),
        .rcv_data(rcv_data), .rcv_ready(rcv_ready), .dut_vec(dut_vec),
        .dut_vec_upd(dut_vec_upd), .freeze_clk(freeze_clk), .wd_err(wd_err)
    );

    typedef struct {
        logic        r;
        logic [2:0]  m;
        logic [2:0]  v;
        logic [26:0] d;
        logic [2:0]  rdy;
        logic [26:0] vec;
        logic [2:0]  upd;
        logic [2:0]  frz;
        logic [2:0]  err;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [26:0] pk(input logic [8:0] s0, input logic [8:0] s1, input logic [8:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic [2:0] m, input logic [2:0] v, input logic [26:0] d);
        @(negedge clk_i);
        rst_i = r; mclk_h = m; rcv_valid = v; rcv_data = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 3'b000, 27'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 27'd0,                     3'b111, pk(9'h000, 9'h000, 9'h000), 3'b000, 3'b111, 3'b000};
        tbl[1]  = '{1'b0, 3'b000, 3'b001, pk(9'h1A5, 9'h000, 9'h000), 3'b111, pk(9'h000, 9'h000, 9'h000), 3'b000, 3'b111, 3'b000};
        tbl[2]  = '{1'b0, 3'b000, 3'b000, 27'd0,                     3'b111, pk(9'h1A5, 9'h000, 9'h000), 3'b001, 3'b110, 3'b000};
        tbl[3]  = '{1'b0, 3'b000, 3'b000, 27'd0,                     3'b111, pk(9'h1A5, 9'h000, 9'h000), 3'b000, 3'b110, 3'b000};
        tbl[4]  = '{1'b0, 3'b001, 3'b000, 27'd0,                     3'b111, pk(9'h1A5, 9'h000, 9'h000), 3'b000, 3'b111, 3'b000};
        tbl[5]  = '{1'b0, 3'b000, 3'b011, pk(9'h0FF, 9'h101, 9'h000), 3'b111, pk(9'h1A5, 9'h000, 9'h000), 3'b000, 3'b111, 3'b000};
        tbl[6]  = '{1'b0, 3'b000, 3'b000, 27'd0,                     3'b111, pk(9'h0FF, 9'h101, 9'h000), 3'b011, 3'b100, 3'b000};
        tbl[7]  = '{1'b0, 3'b010, 3'b010, pk(9'h000, 9'h102, 9'h000), 3'b111, pk(9'h0FF, 9'h101, 9'h000), 3'b000, 3'b110, 3'b000};
        tbl[8]  = '{1'b0, 3'b000, 3'b000, 27'd0,                     3'b111, pk(9'h0FF, 9'h102, 9'h000), 3'b010, 3'b100, 3'b000};
        tbl[9]  = '{1'b0, 3'b001, 3'b100, pk(9'h000, 9'h000, 9'h1C3), 3'b111, pk(9'h0FF, 9'h102, 9'h000), 3'b000, 3'b101, 3'b000};
        tbl[10] = '{1'b0, 3'b000, 3'b000, 27'd0,                     3'b111, pk(9'h0FF, 9'h102, 9'h1C3), 3'b100, 3'b001, 3'b000};
        tbl[11] = '{1'b0, 3'b001, 3'b000, 27'd0,                     3'b111, pk(9'h0FF, 9'h102, 9'h1C3), 3'b000, 3'b001, 3'b000};

        // Reset, then hold with no stimulus.
        step(1'b1, 3'b000, 3'b000, 27'd0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 3'b000, 3'b000, 27'd0);
            chk("hold_ctl", {freeze_clk, rcv_ready, wd_err, dut_vec_upd}, {3'b111, 3'b111, 3'b000, 3'b000});
            chk("hold_vec", dut_vec, 32'd0);
        end

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_rdy", i), rcv_ready,   tbl[i].rdy);
            chk($sformatf("tbl%0d_vec", i), dut_vec,     tbl[i].vec);
            chk($sformatf("tbl%0d_upd", i), dut_vec_upd, tbl[i].upd);
            chk($sformatf("tbl%0d_frz", i), freeze_clk,  tbl[i].frz);
            chk($sformatf("tbl%0d_err", i), wd_err,      tbl[i].err);
        end

        // Slot 1 fill to full, drop a fifth push, then drain with edges.
        step(1'b1, 3'b000, 3'b000, 27'd0);
        step(1'b0, 3'b000, 3'b010, pk(9'h000, 9'h1AA, 9'h000));
        idle(1);
        chk("fill_first", dut_vec[17:9], 9'h1AA);
        chk("fill_run", freeze_clk[1], 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b000, 3'b010, pk(9'h000, 9'(9'h101 + i), 9'h000));
            chk($sformatf("fill_rdy%0d", i), rcv_ready[1], (i == 3) ? 1'b0 : 1'b1);
        end
        step(1'b0, 3'b000, 3'b010, pk(9'h000, 9'h1FF, 9'h000));
        chk("fill_drop_rdy", rcv_ready[1], 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b010, 3'b000, 27'd0);
            chk($sformatf("drain_vec%0d", i), dut_vec[17:9], 9'(9'h101 + i));
            chk($sformatf("drain_upd%0d", i), dut_vec_upd[1], 1'b1);
            chk($sformatf("drain_rdy%0d", i), rcv_ready[1], 1'b1);
            step(1'b0, 3'b000, 3'b000, 27'd0);
            chk($sformatf("drain_frz%0d", i), freeze_clk[1], 1'b0);
        end
        step(1'b0, 3'b010, 3'b000, 27'd0);
        chk("drain_starve_frz", freeze_clk[1], 1'b1);
        chk("drain_starve_vec", dut_vec[17:9], 9'h104);

        // Slot 2 watchdog expiry and stickiness.
        step(1'b1, 3'b000, 3'b000, 27'd0);
        step(1'b0, 3'b000, 3'b100, pk(9'h000, 9'h000, 9'h077));
        idle(1);
        step(1'b0, 3'b100, 3'b000, 27'd0);
        chk("wd_frz_rise", freeze_clk[2], 1'b1);
        for (int j = 1; j <= 25; j++) begin
            step(1'b0, 3'b000, 3'b000, 27'd0);
            if (j == 20) chk("wd_early", wd_err[2], 1'b0);
            if (j >= 21) chk($sformatf("wd_set%0d", j), wd_err[2], 1'b1);
        end
        step(1'b0, 3'b000, 3'b100, pk(9'h000, 9'h000, 9'h1EE));
        idle(2);
        chk("wd_no_release_frz", freeze_clk[2], 1'b1);
        chk("wd_no_release_vec", dut_vec[26:18], 9'h077);
        chk("wd_sticky", wd_err[2], 1'b1);
        step(1'b1, 3'b000, 3'b000, 27'd0);
        chk("wd_rst_err", wd_err, 3'b000);
        chk("wd_rst_frz", freeze_clk, 3'b111);

        // Slot 0 starved briefly, released by a push, then watchdog restarts from zero.
        step(1'b0, 3'b000, 3'b001, pk(9'h010, 9'h000, 9'h000));
        idle(1);
        step(1'b0, 3'b001, 3'b000, 27'd0);
        chk("st_frz_rise", freeze_clk[0], 1'b1);
        idle(4);
        step(1'b0, 3'b000, 3'b001, pk(9'h0FF, 9'h000, 9'h000));
        chk("st_push_frz", freeze_clk[0], 1'b1);
        idle(1);
        chk("st_rel_frz", freeze_clk[0], 1'b0);
        chk("st_rel_vec", dut_vec[8:0], 9'h0FF);
        chk("st_rel_upd", dut_vec_upd[0], 1'b1);
        chk("st_rel_err", wd_err[0], 1'b0);
        step(1'b0, 3'b001, 3'b000, 27'd0);
        chk("st2_frz_rise", freeze_clk[0], 1'b1);
        for (int j = 1; j <= 21; j++) begin
            step(1'b0, 3'b000, 3'b000, 27'd0);
            if (j == 20) chk("st2_wd_early", wd_err[0], 1'b0);
            if (j == 21) chk("st2_wd_set", wd_err[0], 1'b1);
        end

        // Reset mid-run with buffered vectors.
        step(1'b1, 3'b000, 3'b000, 27'd0);
        step(1'b0, 3'b000, 3'b011, pk(9'h011, 9'h022, 9'h000));
        idle(1);
        chk("mr_run_vec", dut_vec, pk(9'h011, 9'h022, 9'h000));
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 3'b010, pk(9'h000, 9'(9'h031 + i), 9'h000));
        step(1'b1, 3'b000, 3'b000, 27'd0);
        chk("mr_rdy", rcv_ready, 3'b111);
        chk("mr_vec", dut_vec, 32'd0);
        chk("mr_upd", dut_vec_upd, 3'b000);
        chk("mr_frz", freeze_clk, 3'b111);
        chk("mr_err", wd_err, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b111, 3'b000, 27'd0);
            step(1'b0, 3'b000, 3'b000, 27'd0);
            chk($sformatf("mr_stale_vec%0d", i), dut_vec, 32'd0);
            chk($sformatf("mr_stale_frz%0d", i), freeze_clk, 3'b111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
